// File: rtl/lfsr_param.sv
// Parameterised LFSR with Fibonacci/Galois step, seed-return period measurement
// and an all-zero lockup state that only reset or a nonzero load can leave.
module lfsr_param #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(16'hB400),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(16'hACE1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             mode_in,
  output logic [WIDTH-1:0] state_out,
  output logic             out,
  output logic             valid,
  output logic             period_done,
  output logic [WIDTH-1:0] period_len,
  output logic             lockup
);

  typedef enum logic {
    RUN  = 1'b0,
    LOCK = 1'b1
  } fsm_e;

  fsm_e             r_fsm;
  fsm_e             w_fsm_nxt;
  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_seed;
  logic             r_mode;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_plen;
  logic             r_valid;
  logic             r_pd;
  logic             r_lockup;

  logic [WIDTH-1:0] w_fib;
  logic [WIDTH-1:0] w_gal;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_state_nxt;
  logic [WIDTH-1:0] w_seed_nxt;
  logic             w_mode_nxt;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_plen_nxt;
  logic             w_valid_nxt;
  logic             w_pd_nxt;
  logic             w_lockup_nxt;

  // One-step successors for both feedback structures; mode_q selects which is used.
  always_comb begin
    w_fib  = {r_state[WIDTH-2:0], ^(r_state & TAPS)};
    w_gal  = {r_state[WIDTH-2:0], 1'b0} ^ (r_state[WIDTH-1] ? TAPS : '0);
    w_step = r_mode ? w_gal : w_fib;
  end

  // Next-state and output decode: load beats en, and en is ignored in LOCK.
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_seed_nxt  = r_seed;
    w_mode_nxt  = r_mode;
    w_count_nxt = r_count;
    w_plen_nxt  = r_plen;
    w_valid_nxt = 1'b0;
    w_pd_nxt    = 1'b0;

    if (load) begin
      if (seed_in != '0) begin
        w_state_nxt = seed_in;
        w_seed_nxt  = seed_in;
        w_mode_nxt  = mode_in;
        w_count_nxt = '0;
        w_fsm_nxt   = RUN;
      end else begin
        w_state_nxt = '0;
        w_fsm_nxt   = LOCK;
      end
    end else if (en && (r_fsm == RUN)) begin
      w_state_nxt = w_step;
      w_valid_nxt = 1'b1;
      if (w_step == r_seed) begin
        w_plen_nxt  = r_count + WIDTH'(1);
        w_count_nxt = '0;
        w_pd_nxt    = 1'b1;
      end else begin
        w_count_nxt = r_count + WIDTH'(1);
      end
    end

    w_lockup_nxt = (w_fsm_nxt == LOCK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm    <= RUN;
      r_state  <= SEED;
      r_seed   <= SEED;
      r_mode   <= 1'b0;
      r_count  <= '0;
      r_plen   <= '0;
      r_valid  <= 1'b0;
      r_pd     <= 1'b0;
      r_lockup <= 1'b0;
    end else begin
      r_fsm    <= w_fsm_nxt;
      r_state  <= w_state_nxt;
      r_seed   <= w_seed_nxt;
      r_mode   <= w_mode_nxt;
      r_count  <= w_count_nxt;
      r_plen   <= w_plen_nxt;
      r_valid  <= w_valid_nxt;
      r_pd     <= w_pd_nxt;
      r_lockup <= w_lockup_nxt;
    end
  end

  assign state_out   = r_state;
  assign out         = r_state[WIDTH-1];
  assign valid       = r_valid;
  assign period_done = r_pd;
  assign period_len  = r_plen;
  assign lockup      = r_lockup;

endmodule

// File: tb/tb_lfsr_param.sv
// Scoreboard bench for lfsr_param at WIDTH=4: one Fibonacci and one Galois instance,
// expected step results queued by the stimulus and checked by per-instance monitors.
module tb_lfsr_param;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst;

  logic         a_en, a_load, a_mode;
  logic [W-1:0] a_seed;
  logic [W-1:0] a_state, a_plen;
  logic         a_out, a_valid, a_pd, a_lock;

  logic         b_en, b_load, b_mode;
  logic [W-1:0] b_seed;
  logic [W-1:0] b_state, b_plen;
  logic         b_out, b_valid, b_pd, b_lock;

  lfsr_param #(.WIDTH(W), .TAPS(4'b1100), .SEED(4'b1010)) u_fib (
    .clk(clk), .rst(rst), .en(a_en), .load(a_load), .seed_in(a_seed), .mode_in(a_mode),
    .state_out(a_state), .out(a_out), .valid(a_valid), .period_done(a_pd),
    .period_len(a_plen), .lockup(a_lock)
  );

  lfsr_param #(.WIDTH(W), .TAPS(4'b0011), .SEED(4'b0001)) u_gal (
    .clk(clk), .rst(rst), .en(b_en), .load(b_load), .seed_in(b_seed), .mode_in(b_mode),
    .state_out(b_state), .out(b_out), .valid(b_valid), .period_done(b_pd),
    .period_len(b_plen), .lockup(b_lock)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] st;
    logic         pd;
    logic [W-1:0] plen;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb, en_item;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [W-1:0] a_plen_exp = '0;
  logic [W-1:0] b_plen_exp = '0;

  logic [W-1:0] fib_tab[15] = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010,
                                4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000,
                                4'b0001};
  logic [W-1:0] gal_tab[15] = '{4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b0110, 4'b1100, 4'b1011,
                                4'b0101, 4'b1010, 4'b0111, 4'b1110, 4'b1111, 4'b1101, 4'b1001,
                                4'b0001};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Queue one expected step on the Fibonacci instance and let the edge happen.
  task automatic a_step(input logic [W-1:0] st, input logic pd);
    if (pd) a_plen_exp = 4'd15;
    en_item.st   = st;
    en_item.pd   = pd;
    en_item.plen = a_plen_exp;
    q_a.push_back(en_item);
    a_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic b_step(input logic [W-1:0] st, input logic pd);
    if (pd) b_plen_exp = 4'd15;
    en_item.st   = st;
    en_item.pd   = pd;
    en_item.plen = b_plen_exp;
    q_b.push_back(en_item);
    b_en = 1'b1;
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (a_valid === 1'b1) begin
      if (q_a.size() == 0) chk("a_unexpected_valid", 32'(a_valid), 32'(0));
      else begin
        ea = q_a.pop_front();
        chk("a_state", 32'(a_state), 32'(ea.st));
        chk("a_out", 32'(a_out), 32'(ea.st[W-1]));
        chk("a_period_done", 32'(a_pd), 32'(ea.pd));
        chk("a_period_len", 32'(a_plen), 32'(ea.plen));
      end
    end else if (a_pd !== 1'b0) chk("a_pd_without_valid", 32'(a_pd), 32'(0));
  end

  always @(posedge clk) begin
    #1;
    if (b_valid === 1'b1) begin
      if (q_b.size() == 0) chk("b_unexpected_valid", 32'(b_valid), 32'(0));
      else begin
        eb = q_b.pop_front();
        chk("b_state", 32'(b_state), 32'(eb.st));
        chk("b_out", 32'(b_out), 32'(eb.st[W-1]));
        chk("b_period_done", 32'(b_pd), 32'(eb.pd));
        chk("b_period_len", 32'(b_plen), 32'(eb.plen));
      end
    end else if (b_pd !== 1'b0) chk("b_pd_without_valid", 32'(b_pd), 32'(0));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_en = 1'b0; a_load = 1'b0; a_mode = 1'b0; a_seed = '0;
    b_en = 1'b0; b_load = 1'b0; b_mode = 1'b0; b_seed = '0;
    repeat (2) @(negedge clk);

    chk("rst_state", 32'(a_state), 32'(4'b1010));
    chk("rst_out", 32'(a_out), 32'(1));
    chk("rst_valid", 32'(a_valid), 32'(0));
    chk("rst_period_done", 32'(a_pd), 32'(0));
    chk("rst_period_len", 32'(a_plen), 32'(0));
    chk("rst_lockup", 32'(a_lock), 32'(0));
    chk("rst_b_state", 32'(b_state), 32'(4'b0001));
    rst = 1'b0;

    // Load and en together: load wins, no step this cycle.
    a_load = 1'b1; a_seed = 4'b0001; a_mode = 1'b0; a_en = 1'b1;
    @(negedge clk);
    a_load = 1'b0;
    chk("load_en_state", 32'(a_state), 32'(4'b0001));
    chk("load_en_valid", 32'(a_valid), 32'(0));

    for (int i = 0; i < 15; i++) a_step(fib_tab[i], i == 14);
    a_en = 1'b0;
    @(negedge clk);
    chk("fib_period_len", 32'(a_plen), 32'(15));
    chk("fib_idle_valid", 32'(a_valid), 32'(0));
    repeat (3) @(negedge clk);
    chk("fib_idle_hold", 32'(a_state), 32'(4'b0001));

    // en toggling every cycle: state moves only on enabled cycles.
    for (int i = 0; i < 15; i++) begin
      a_step(fib_tab[i], i == 14);
      a_en = 1'b0;
      @(negedge clk);
      chk("toggle_hold", 32'(a_state), 32'(fib_tab[i]));
    end
    chk("toggle_period_len", 32'(a_plen), 32'(15));

    // Galois instance; mode pin released right after load must not matter.
    b_load = 1'b1; b_seed = 4'b0001; b_mode = 1'b1;
    @(negedge clk);
    b_load = 1'b0; b_mode = 1'b0;
    for (int i = 0; i < 15; i++) b_step(gal_tab[i], i == 14);
    b_en = 1'b0;
    @(negedge clk);
    chk("gal_period_len", 32'(b_plen), 32'(15));

    // Zero load enters LOCK; en is ignored there.
    a_load = 1'b1; a_seed = 4'b0000;
    @(negedge clk);
    a_load = 1'b0;
    chk("lock_entry", 32'(a_lock), 32'(1));
    chk("lock_state0", 32'(a_state), 32'(0));
    a_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("lock_state", 32'(a_state), 32'(0));
      chk("lock_valid", 32'(a_valid), 32'(0));
    end
    a_en = 1'b0;
    chk("lock_held", 32'(a_lock), 32'(1));
    chk("lock_period_len_kept", 32'(a_plen), 32'(15));
    a_load = 1'b1; a_seed = 4'b0001;
    @(negedge clk);
    a_load = 1'b0;
    chk("lock_exit", 32'(a_lock), 32'(0));
    chk("lock_exit_state", 32'(a_state), 32'(4'b0001));
    for (int i = 0; i < 3; i++) a_step(fib_tab[i], 1'b0);
    a_en = 1'b0;

    // Reset at step 7 with load and en also high: reset wins.
    a_load = 1'b1; a_seed = 4'b0001;
    @(negedge clk);
    a_load = 1'b0;
    for (int i = 0; i < 7; i++) a_step(fib_tab[i], 1'b0);
    rst = 1'b1; a_load = 1'b1; a_seed = 4'b0101;
    @(negedge clk);
    rst = 1'b0; a_load = 1'b0; a_en = 1'b0;
    a_plen_exp = '0;
    b_plen_exp = '0;
    chk("midrst_state", 32'(a_state), 32'(4'b1010));
    chk("midrst_period_len", 32'(a_plen), 32'(0));
    chk("midrst_valid", 32'(a_valid), 32'(0));
    chk("midrst_period_done", 32'(a_pd), 32'(0));
    chk("midrst_lockup", 32'(a_lock), 32'(0));

    // mode pin outside a load cycle keeps the Fibonacci step from reset.
    a_mode = 1'b1;
    a_step(4'b0101, 1'b0);
    a_step(4'b1011, 1'b0);
    a_en = 1'b0; a_mode = 1'b0;

    repeat (3) @(negedge clk);
    chk("a_queue_drained", 32'(q_a.size()), 32'(0));
    chk("b_queue_drained", 32'(q_b.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
